multi_channel_clock_divider: RTL and testbench

MULTI_CHANNEL_CLOCK_DIVIDER -- requirements
Module: multi_channel_clock_divider

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clock_divider_channel.sv | 64 ++++++
 rtl/multi_channel_clock_divider.sv | 43 ++++
 tb/tb_multi_channel_clock_divider.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared constants for the multi-channel clock divider.
//   MODE_TOGGLE / MODE_PULSE : per-channel output mode encodings
//   DEFAULT_CNT_W            : default counter/divisor width
package clk_div_pkg;

  localparam logic MODE_TOGGLE   = 1'b0;
  localparam logic MODE_PULSE    = 1'b1;
  localparam int   DEFAULT_CNT_W = 32;

endpackage : clk_div_pkg

// File: rtl/clock_divider_channel.sv
// clock_divider_channel
//   One divider channel. Counts 0..act_m, then emits a one-cycle tick and
//   either toggles slow_clk (toggle mode) or pulses it (pulse mode).
//   The divisor m is only sampled into act_m at terminal count, resync or
//   reset, so a running period always completes at its original length.
// Ports
//   basys_clk  in   system clock, rising edge
//   reset      in   synchronous active-high reset (beats resync)
//   resync     in   synchronous phase-align strobe (beats en / terminal count)
//   en         in   run enable
//   mode       in   0 = toggle, 1 = pulse
//   m          in   terminal count, CNT_W bits
//   slow_clk   out  divided clock, registered
//   tick       out  one-cycle terminal-count strobe, registered
module clock_divider_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic             resync,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] m,
  output logic             slow_clk,
  output logic             tick
);

  // Declaration initialisers give the reset state at FPGA configuration.
  logic [CNT_W-1:0] cnt      = '0;
  logic [CNT_W-1:0] act_m    = '0;
  logic             slow_q   = 1'b1;
  logic             tick_q   = 1'b0;
  logic             term_cnt;

  assign term_cnt = en && (cnt == act_m);

  always_ff @(posedge basys_clk) begin
    if (reset || resync) begin
      cnt    <= '0;
      act_m  <= m;
      slow_q <= 1'b1;
      tick_q <= 1'b0;
    end else if (term_cnt) begin
      cnt    <= '0;
      act_m  <= m;
      tick_q <= 1'b1;
      // Pulse mode mirrors the next tick value; toggle mode flips.
      slow_q <= (mode == MODE_PULSE) ? 1'b1 : ~slow_q;
    end else if (en) begin
      cnt    <= cnt + 1'b1;
      tick_q <= 1'b0;
      slow_q <= (mode == MODE_PULSE) ? 1'b0 : slow_q;
    end else begin
      // Disabled: counter, divisor and slow_clk freeze; tick is dropped.
      tick_q <= 1'b0;
    end
  end

  assign slow_clk = slow_q;
  assign tick     = tick_q;

endmodule : clock_divider_channel

// File: rtl/multi_channel_clock_divider.sv
// multi_channel_clock_divider
//   NUM_CH independent clock divider channels sharing reset and resync.
// Ports
//   basys_clk  in   system clock
//   reset      in   synchronous active-high reset
//   m          in   NUM_CH*CNT_W  per-channel terminal count, ch i at [i*CNT_W +: CNT_W]
//   en         in   NUM_CH        per-channel run enable
//   mode       in   NUM_CH        per-channel mode (0 toggle, 1 pulse)
//   resync     in   phase-align strobe for all channels
//   slow_clk   out  NUM_CH        divided clocks
//   tick       out  NUM_CH        terminal-count strobes
module multi_channel_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    basys_clk,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] m,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       slow_clk,
  output logic [NUM_CH-1:0]       tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .basys_clk (basys_clk),
      .reset     (reset),
      .resync    (resync),
      .en        (en[i]),
      .mode      (mode[i]),
      .m         (m[i*CNT_W +: CNT_W]),
      .slow_clk  (slow_clk[i]),
      .tick      (tick[i])
    );
  end

endmodule : multi_channel_clock_divider

// File: tb/tb_multi_channel_clock_divider.sv
// tb_multi_channel_clock_divider
//   Directed bench for the 4-channel, 32-bit divider. Expected values are
//   closed-form per-edge formulas worked out by hand for each scenario.
module tb_multi_channel_clock_divider;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic                    basys_clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*CNT_W-1:0] m;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic                    resync;
  logic [NUM_CH-1:0]       slow_clk;
  logic [NUM_CH-1:0]       tick;

  int n_cmp = 0;
  int n_bad = 0;

  multi_channel_clock_divider #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .basys_clk (basys_clk),
    .reset     (reset),
    .m         (m),
    .en        (en),
    .mode      (mode),
    .resync    (resync),
    .slow_clk  (slow_clk),
    .tick      (tick)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge basys_clk);
    #1;
  endtask

  logic [NUM_CH-1:0] exp_slow;
  logic [NUM_CH-1:0] exp_tick;

  initial begin
    reset  = 1'b1;
    resync = 1'b0;
    en     = '0;
    mode   = '0;
    m      = {32'd3, 32'd2, 32'd1, 32'd0};

    // Reset state.
    step();
    step();
    check("rst_slow", 32'(slow_clk), 32'hF);
    check("rst_tick", 32'(tick), 32'h0);

    // Four toggle channels, m = 0..3: period 2*(i+1), ch3 first toggles at edge 4.
    reset = 1'b0;
    en    = 4'hF;
    for (int k = 1; k <= 24; k++) begin
      step();
      for (int i = 0; i < NUM_CH; i++) begin
        exp_tick[i] = ((k % (i + 1)) == 0);
        exp_slow[i] = 1'b1 ^ 1'((k / (i + 1)) & 1);
      end
      check($sformatf("tog_slow k=%0d", k), 32'(slow_clk), 32'(exp_slow));
      check($sformatf("tog_tick k=%0d", k), 32'(tick), 32'(exp_tick));
      if (k == 3) check("ch3_pre_toggle", 32'(slow_clk[3]), 32'h1);
      if (k == 4) check("ch3_first_toggle", 32'(slow_clk[3]), 32'h0);
    end

    // ch0 pulse mode, m = 4: tick and slow_clk high one cycle in five.
    m[0 +: 32] = 32'd4;
    mode       = 4'b0001;
    resync     = 1'b1;
    step();
    resync = 1'b0;
    check("rsy_slow", 32'(slow_clk), 32'hF);
    check("rsy_tick", 32'(tick), 32'h0);
    for (int k = 1; k <= 50; k++) begin
      step();
      check($sformatf("pulse ch0 k=%0d", k), {30'd0, tick[0], slow_clk[0]},
            ((k % 5) == 0) ? 32'h3 : 32'h0);
    end

    // ch1 m = 9, switch to 2 at cnt 3: old period ends at edge 10, then 3-cycle periods.
    mode       = 4'b0000;
    m[32 +: 32] = 32'd9;
    resync     = 1'b1;
    step();
    resync = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3) m[32 +: 32] = 32'd2;
      if (k < 10) begin
        exp_tick[1] = 1'b0;
        exp_slow[1] = 1'b1;
      end else begin
        exp_tick[1] = (((k - 10) % 3) == 0);
        exp_slow[1] = 1'((((k - 10) / 3) & 1));
      end
      check($sformatf("mchg ch1 k=%0d", k), {30'd0, tick[1], slow_clk[1]},
            {30'd0, exp_tick[1], exp_slow[1]});
    end

    // ch2 m = 5, en low for edges 3..9 from cnt 2: terminal count moves to edge 13.
    m[64 +: 32] = 32'd5;
    resync      = 1'b1;
    step();
    resync = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      en[2] = !(k >= 3 && k <= 9);
      step();
      check($sformatf("gap ch2 k=%0d", k), {30'd0, tick[2], slow_clk[2]},
            {30'd0, 1'(k == 13), 1'(k < 13)});
    end
    en = 4'hF;

    // Arbitrary phases, then resync; equal-m channels stay aligned for 100 cycles.
    m = {32'd5, 32'd2, 32'd5, 32'd2};
    for (int k = 0; k < 7; k++) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("align_slow0", 32'(slow_clk), 32'hF);
    check("align_tick0", 32'(tick), 32'h0);
    for (int k = 1; k <= 100; k++) begin
      step();
      for (int i = 0; i < NUM_CH; i++) begin
        int per;
        per = ((i % 2) == 0) ? 3 : 6;
        exp_tick[i] = ((k % per) == 0);
        exp_slow[i] = 1'b1 ^ 1'((k / per) & 1);
      end
      check($sformatf("align_slow k=%0d", k), 32'(slow_clk), 32'(exp_slow));
      check($sformatf("align_tick k=%0d", k), 32'(tick), 32'(exp_tick));
    end

    // Reset with resync mid-period, then reset alone, then release.
    step();
    reset  = 1'b1;
    resync = 1'b1;
    step();
    check("rr_slow1", 32'(slow_clk), 32'hF);
    check("rr_tick1", 32'(tick), 32'h0);
    step();
    check("rr_tick2", 32'(tick), 32'h0);
    resync = 1'b0;
    step();
    check("r_slow", 32'(slow_clk), 32'hF);
    check("r_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      check($sformatf("post_rst_tick k=%0d", k), 32'(tick), 32'h0);
      check($sformatf("post_rst_slow k=%0d", k), 32'(slow_clk), 32'hF);
    end

    // m = 0 everywhere: tick stuck high, toggle period 2, pulse slow_clk stuck high.
    m     = '0;
    mode  = 4'b1010;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_slow = {1'b1, ~1'(k & 1), 1'b1, ~1'(k & 1)};
      check($sformatf("m0_tick k=%0d", k), 32'(tick), 32'hF);
      check($sformatf("m0_slow k=%0d", k), 32'(slow_clk), 32'(exp_slow));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_multi_channel_clock_divider
